// File: rtl/fabric_cfg_loader.sv
// ----------------------------------------------------------------------------
// fabric_cfg_loader
//   Loads the 2x2 fabric configuration word from a framed byte stream.
//   Frame: SYNC_BYTE, NBYTES payload bytes (LSB first), XOR checksum byte.
//   Payload bytes go into a shadow register. A matching checksum commits the
//   shadow to config_bits in a single cycle. The fabric is held in reset from
//   the accepted sync byte until one cycle after a successful commit.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   cfg_data     in   [8]  stream byte
//   cfg_valid    in   cfg_data valid
//   cfg_ready    out  byte accepted when cfg_valid && cfg_ready
//   cfg_abort    in   cancel the frame in progress (LOAD/CHECK only)
//   config_bits  out  [CFG_WIDTH] committed configuration
//   fabric_rst_n out  active-low fabric reset
//   cfg_loaded   out  committed configuration is valid
//   cfg_done     out  one-cycle pulse on commit
//   cfg_error    out  sticky error; cleared by reset or the next sync byte
//
// Optional build macro FABRIC_CFG_READBACK_EN adds a readback stream:
//   rb_req in, rb_data out [8], rb_valid out, rb_ready in.
//   The stream is the committed word re-framed as sync, payload, checksum.
// ----------------------------------------------------------------------------
module fabric_cfg_loader #(
    parameter int          CFG_WIDTH = 52,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    localparam int         NBYTES    = (CFG_WIDTH + 7) / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_abort,
    output logic [CFG_WIDTH-1:0] config_bits,
    output logic                 fabric_rst_n,
    output logic                 cfg_loaded,
    output logic                 cfg_done,
    output logic                 cfg_error
`ifdef FABRIC_CFG_READBACK_EN
    ,
    input  logic                 rb_req,
    output logic [7:0]           rb_data,
    output logic                 rb_valid,
    input  logic                 rb_ready
`endif
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SH_W  = NBYTES * 8;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_acc;
    logic [SH_W-1:0]      r_shadow;
    logic [CFG_WIDTH-1:0] r_config_bits;
    logic                 r_fabric_rst_n;
    logic                 r_loaded;
    logic                 r_done;
    logic                 r_error;
    logic                 w_hs;
    logic                 w_sync;
    logic                 w_last;

    assign cfg_ready    = (r_state != COMMIT);
    assign w_hs         = cfg_valid && cfg_ready;
    assign w_sync       = (cfg_data == SYNC_BYTE);
    assign w_last       = (r_cnt == CNT_W'(NBYTES - 1));
    assign config_bits  = r_config_bits;
    assign fabric_rst_n = r_fabric_rst_n;
    assign cfg_loaded   = r_loaded;
    assign cfg_done     = r_done;
    assign cfg_error    = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_hs && w_sync) w_state_nxt = LOAD;
            LOAD:   if (cfg_abort)              w_state_nxt = IDLE;
                    else if (w_hs && w_last)    w_state_nxt = CHECK;
            CHECK:  if (cfg_abort)              w_state_nxt = IDLE;
                    else if (w_hs)              w_state_nxt = (cfg_data == r_acc) ? COMMIT : IDLE;
            COMMIT: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_acc          <= '0;
            r_shadow       <= '0;
            r_config_bits  <= '0;
            r_fabric_rst_n <= 1'b0;
            r_loaded       <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_done <= (r_state == COMMIT);
            // Release the fabric the cycle after config_bits changed; a sync
            // byte arriving in that same cycle wins and keeps it in reset.
            if (r_done) r_fabric_rst_n <= 1'b1;
            case (r_state)
                IDLE: if (w_hs && w_sync) begin
                    r_cnt          <= '0;
                    r_acc          <= '0;
                    r_error        <= 1'b0;
                    r_fabric_rst_n <= 1'b0;
                    r_loaded       <= 1'b0;
                end
                LOAD: if (cfg_abort) begin
                    r_error <= 1'b1;
                end else if (w_hs) begin
                    r_shadow[{r_cnt, 3'b000} +: 8] <= cfg_data;
                    r_acc <= r_acc ^ cfg_data;
                    r_cnt <= r_cnt + 1'b1;
                end
                CHECK: if (cfg_abort || (w_hs && cfg_data != r_acc)) begin
                    r_error <= 1'b1;
                end
                COMMIT: begin
                    r_config_bits <= r_shadow[CFG_WIDTH-1:0];
                    r_loaded      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FABRIC_CFG_READBACK_EN
    localparam int RB_W = (NBYTES + 2) * 8;

    logic [RB_W-1:0]  r_rb_buf;
    logic             r_rb_busy;
    logic [3:0]       r_rb_idx;
    logic [SH_W-1:0]  w_rb_word;
    logic [7:0]       w_rb_ck;

    assign w_rb_word = SH_W'(r_config_bits);   // pad bits read back as 0

    always_comb begin
        w_rb_ck = '0;
        for (int k = 0; k < NBYTES; k++) w_rb_ck = w_rb_ck ^ w_rb_word[k*8 +: 8];
    end

    // The whole frame is latched at request time, so a later commit cannot
    // change bytes still waiting to be streamed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb_buf  <= '0;
            r_rb_busy <= 1'b0;
            r_rb_idx  <= '0;
        end else if (r_rb_busy) begin
            if (rb_ready) begin
                r_rb_buf <= r_rb_buf >> 8;
                r_rb_idx <= r_rb_idx + 1'b1;
                if (r_rb_idx == 4'(NBYTES + 1)) r_rb_busy <= 1'b0;
            end
        end else if (rb_req && r_loaded) begin
            r_rb_buf  <= {w_rb_ck, w_rb_word, SYNC_BYTE};
            r_rb_busy <= 1'b1;
            r_rb_idx  <= '0;
        end
    end

    assign rb_data  = r_rb_buf[7:0];
    assign rb_valid = r_rb_busy;
`endif

endmodule
